// File: rtl/config_sequencer_pkg.sv
// rtl/config_sequencer_pkg.sv - UART configuration types, packet constants and helpers
package config_sequencer_pkg;

   typedef struct packed {
      logic [1:0] data_width;
      logic [1:0] parity_mode;
      logic [1:0] stop_bits;
   } uart_config_s;

   localparam logic [1:0] DW_5BIT       = 2'b00;
   localparam logic [1:0] DW_6BIT       = 2'b01;
   localparam logic [1:0] DW_7BIT       = 2'b10;
   localparam logic [1:0] DW_8BIT       = 2'b11;
   localparam logic [1:0] PARITY_NONE   = 2'b00;
   localparam logic [1:0] PARITY_EVEN   = 2'b01;
   localparam logic [1:0] PARITY_ODD    = 2'b10;
   localparam logic [1:0] STOP_1        = 2'b00;
   localparam logic [1:0] STOP_2        = 2'b01;
   localparam logic [1:0] STOP_1_5      = 2'b10;
   localparam logic [1:0] STOP_RESERVED = 2'b11;

   localparam logic [1:0] STD_DATA_WIDTH  = DW_8BIT;
   localparam logic [1:0] STD_PARITY_MODE = PARITY_NONE;
   localparam logic [1:0] STD_STOP_BITS   = STOP_1;

   localparam int COUNT_50MS = 5_000_000;

   typedef enum logic [2:0] {
      SEQ_IDLE,
      SEQ_SEND,
      SEQ_WAIT_ACK,
      SEQ_DONE,
      SEQ_FAIL
   } config_seq_fsm_e;

   localparam logic [7:0] REQ_PKT  = 8'hC0;
   localparam logic [7:0] ACKN_PKT = 8'hFF;

   localparam logic [5:0] DATA_WIDTH_ID = 6'h31;
   localparam logic [5:0] PARITY_ID     = 6'h32;
   localparam logic [5:0] STOP_BITS_ID  = 6'h33;
   localparam logic [5:0] END_ID        = 6'h34;

   function automatic logic [7:0] assemble_packet(input logic [5:0] id, input logic [1:0] option);
      return {id, option};
   endfunction

endpackage

// File: rtl/timeout_counter.sv
// rtl/timeout_counter.sv - acknowledge wait timer with clear, enable and expire
module timeout_counter #(
   parameter int CYCLES = 100
) (
   input  logic clk_i,
   input  logic rst_n_i,
   input  logic clear,
   input  logic enable,
   output logic expire
);

   localparam int W = (CYCLES > 1) ? $clog2(CYCLES) : 1;
   localparam logic [W-1:0] LAST = W'(CYCLES - 1);

   logic [W-1:0] count;

   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (enable) begin
         count <= count + 1'b1;
      end
   end

   assign expire = (count == LAST);

endmodule

// File: rtl/config_sequencer.sv
// rtl/config_sequencer.sv - sends the UART configuration packet sequence and awaits acknowledges
module config_sequencer
   import config_sequencer_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = COUNT_50MS,
   parameter int MAX_RETRY      = 3
) (
   input  logic         clk_i,
   input  logic         rst_n_i,
   input  logic         start_i,
   input  uart_config_s config_i,
   input  logic         tx_fifo_full_i,
   output logic         tx_fifo_write_o,
   output logic [7:0]   data_tx_o,
   input  logic         rx_fifo_empty_i,
   output logic         rx_fifo_read_o,
   input  logic [7:0]   data_rx_i,
   output logic         busy_o,
   output logic         data_stream_mode_o,
   output logic         done_o,
   output logic         fail_o,
   output logic         illegal_o
);

   localparam logic [2:0] LAST_STEP   = 3'd4;
   localparam logic [1:0] RETRY_LIMIT = 2'(MAX_RETRY);

   config_seq_fsm_e state, state_next;
   logic [2:0]      step, step_next;
   logic [1:0]      retry, retry_next;
   uart_config_s    cfg;
   logic            illegal;
   logic            start_accept;
   logic            write, read;
   logic            timer_clear, timer_en, timer_expire;
   logic [7:0]      packet;

   timeout_counter #(.CYCLES(TIMEOUT_CYCLES)) u_timer (
      .clk_i   (clk_i),
      .rst_n_i (rst_n_i),
      .clear   (timer_clear),
      .enable  (timer_en),
      .expire  (timer_expire)
   );

   // Reserved stop-bit encoding is swapped for the standard one at latch time.
   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         state   <= SEQ_IDLE;
         step    <= '0;
         retry   <= '0;
         cfg     <= '0;
         illegal <= 1'b0;
      end else begin
         state <= state_next;
         step  <= step_next;
         retry <= retry_next;
         if (start_accept) begin
            cfg.data_width  <= config_i.data_width;
            cfg.parity_mode <= config_i.parity_mode;
            cfg.stop_bits   <= (config_i.stop_bits == STOP_RESERVED) ? STD_STOP_BITS
                                                                      : config_i.stop_bits;
            illegal         <= (config_i.stop_bits == STOP_RESERVED);
         end
      end
   end

   always_comb begin
      state_next   = state;
      step_next    = step;
      retry_next   = retry;
      start_accept = 1'b0;
      write        = 1'b0;
      read         = 1'b0;
      timer_clear  = 1'b0;
      timer_en     = 1'b0;
      case (state)
         SEQ_IDLE: begin
            if (start_i) begin
               start_accept = 1'b1;
               step_next    = '0;
               retry_next   = '0;
               state_next   = SEQ_SEND;
            end
         end
         SEQ_SEND: begin
            if (!tx_fifo_full_i) begin
               write       = 1'b1;
               timer_clear = 1'b1;
               state_next  = SEQ_WAIT_ACK;
            end
         end
         SEQ_WAIT_ACK: begin
            // A received byte takes priority over a timer expiring in the same cycle.
            if (!rx_fifo_empty_i) begin
               read = 1'b1;
               if (data_rx_i != ACKN_PKT) begin
                  state_next = SEQ_FAIL;
               end else if (step == LAST_STEP) begin
                  state_next = SEQ_DONE;
               end else begin
                  step_next  = step + 3'd1;
                  retry_next = '0;
                  state_next = SEQ_SEND;
               end
            end else if (timer_expire) begin
               if (retry < RETRY_LIMIT) begin
                  retry_next = retry + 2'd1;
                  state_next = SEQ_SEND;
               end else begin
                  state_next = SEQ_FAIL;
               end
            end else begin
               timer_en = 1'b1;
            end
         end
         SEQ_DONE: state_next = SEQ_IDLE;
         SEQ_FAIL: state_next = SEQ_IDLE;
         default:  state_next = SEQ_IDLE;
      endcase
   end

   always_comb begin
      packet = REQ_PKT;
      case (step)
         3'd1:    packet = assemble_packet(DATA_WIDTH_ID, cfg.data_width);
         3'd2:    packet = assemble_packet(PARITY_ID, cfg.parity_mode);
         3'd3:    packet = assemble_packet(STOP_BITS_ID, cfg.stop_bits);
         3'd4:    packet = assemble_packet(END_ID, 2'b00);
         default: packet = REQ_PKT;
      endcase
   end

   assign tx_fifo_write_o    = write;
   assign data_tx_o          = (state == SEQ_SEND) ? packet : 8'h00;
   assign rx_fifo_read_o     = read;
   assign busy_o             = (state != SEQ_IDLE);
   assign data_stream_mode_o = busy_o;
   assign done_o             = (state == SEQ_DONE);
   assign fail_o             = (state == SEQ_FAIL);
   assign illegal_o          = illegal;

endmodule

// File: tb/tb_config_sequencer.sv
// tb/tb_config_sequencer.sv - randomized self-checking bench for config_sequencer
module tb_config_sequencer;
   import config_sequencer_pkg::*;

   localparam int T        = 100;
   localparam int MR       = 3;
   localparam int ACT_ACK  = 0;
   localparam int ACT_DROP = 1;
   localparam int ACT_BAD  = 2;
   localparam int MAX_ATT  = 20;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic         rst_n_i, start_i, tx_fifo_full_i, rx_fifo_empty_i;
   uart_config_s config_i;
   logic [7:0]   data_rx_i, data_tx_o;
   logic         tx_fifo_write_o, rx_fifo_read_o, busy_o, data_stream_mode_o;
   logic         done_o, fail_o, illegal_o;

   config_sequencer #(.TIMEOUT_CYCLES(T), .MAX_RETRY(MR)) dut (
      .clk_i              (clk),
      .rst_n_i            (rst_n_i),
      .start_i            (start_i),
      .config_i           (config_i),
      .tx_fifo_full_i     (tx_fifo_full_i),
      .tx_fifo_write_o    (tx_fifo_write_o),
      .data_tx_o          (data_tx_o),
      .rx_fifo_empty_i    (rx_fifo_empty_i),
      .rx_fifo_read_o     (rx_fifo_read_o),
      .data_rx_i          (data_rx_i),
      .busy_o             (busy_o),
      .data_stream_mode_o (data_stream_mode_o),
      .done_o             (done_o),
      .fail_o             (fail_o),
      .illegal_o          (illegal_o)
   );

   int checks = 0;
   int errors = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Remote device plan: one action per transmitted packet attempt.
   int         act[MAX_ATT];
   int         dly[MAX_ATT];
   logic [7:0] bad_byte[MAX_ATT];
   logic [1:0] c_dw, c_par, c_sb;
   int         full_rel;

   int         cyc = 0;
   int         full_until = 0;
   logic [7:0] rxq[$];
   bit         pop_pending = 0;
   bit         sched_valid = 0;
   int         sched_edge;
   logic [7:0] sched_byte;

   int         obs_w_edge[$];
   logic [7:0] obs_pkt[$];
   int         obs_reads, obs_done, obs_fail, end_edge, dsm_bad, wrote_full;

   int         exp_w_off[$];
   logic [7:0] exp_pkt[$];
   int         exp_reads, exp_done, exp_fail, exp_end_off;
   logic       exp_illegal;

   task automatic drive_inputs();
      tx_fifo_full_i  = (cyc + 1 <= full_until);
      rx_fifo_empty_i = (rxq.size() == 0);
      data_rx_i       = (rxq.size() == 0) ? 8'hFF : rxq[0];
   endtask

   task automatic observe();
      int e = cyc + 1;
      int a;
      if (busy_o !== data_stream_mode_o) dsm_bad++;
      if (tx_fifo_write_o) begin
         if (tx_fifo_full_i) wrote_full++;
         obs_w_edge.push_back(e);
         obs_pkt.push_back(data_tx_o);
         a = obs_pkt.size() - 1;
         if (a < MAX_ATT && act[a] != ACT_DROP) begin
            sched_valid = 1;
            sched_edge  = e + dly[a];
            sched_byte  = (act[a] == ACT_ACK) ? 8'hFF : bad_byte[a];
         end
      end
      if (rx_fifo_read_o) begin
         obs_reads++;
         pop_pending = 1;
      end
      if (done_o) begin
         obs_done++;
         end_edge = e;
      end
      if (fail_o) begin
         obs_fail++;
         end_edge = e;
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
      start_i = 1'b0;
      if (pop_pending && rxq.size() > 0) void'(rxq.pop_front());
      pop_pending = 0;
      if (sched_valid && sched_edge == cyc + 1) begin
         rxq.push_back(sched_byte);
         sched_valid = 0;
      end
      drive_inputs();
      @(negedge clk);
      observe();
   endtask

   function automatic logic [7:0] ref_pkt(input int s);
      logic [1:0] sb = (c_sb == 2'b11) ? 2'b00 : c_sb;
      case (s)
         0:       return 8'hC0;
         1:       return 8'hC4 | {6'b0, c_dw};
         2:       return 8'hC8 | {6'b0, c_par};
         3:       return 8'hCC | {6'b0, sb};
         default: return 8'hD0;
      endcase
   endfunction

   // Walks the plan attempt by attempt; offsets are edges relative to the start edge.
   task automatic predict();
      int w = 1 + full_rel;
      int s = 0;
      int r = 0;
      int a = 0;
      bit fin = 0;
      exp_w_off.delete();
      exp_pkt.delete();
      exp_reads = 0; exp_done = 0; exp_fail = 0; exp_end_off = 0;
      exp_illegal = (c_sb == 2'b11);
      while (!fin) begin
         exp_w_off.push_back(w);
         exp_pkt.push_back(ref_pkt(s));
         if (act[a] == ACT_ACK) begin
            exp_reads++;
            if (s == 4) begin
               exp_done = 1; exp_end_off = w + dly[a] + 1; fin = 1;
            end else begin
               s++; r = 0; w = w + dly[a] + 1;
            end
         end else if (act[a] == ACT_BAD) begin
            exp_reads++;
            exp_fail = 1; exp_end_off = w + dly[a] + 1; fin = 1;
         end else if (r < MR) begin
            r++; w = w + T + 1;
         end else begin
            exp_fail = 1; exp_end_off = w + T + 1; fin = 1;
         end
         a++;
         if (a >= MAX_ATT) fin = 1;
      end
   endtask

   task automatic clear_obs();
      obs_w_edge.delete();
      obs_pkt.delete();
      obs_reads = 0; obs_done = 0; obs_fail = 0; end_edge = 0; dsm_bad = 0; wrote_full = 0;
      rxq.delete();
      sched_valid = 0;
      pop_pending = 0;
   endtask

   task automatic run_scenario(input string name);
      int n;
      int budget = 0;
      int cnt;
      predict();
      clear_obs();
      config_i   = {c_dw, c_par, c_sb};
      n          = cyc + 1;
      full_until = n + full_rel;
      start_i    = 1'b1;
      tick();
      check_eq({name, " busy_after_start"}, 32'(busy_o), 32'd1);
      repeat (4) tick();
      config_i = ~config_i;
      start_i  = 1'b1;
      while (obs_done + obs_fail == 0 && budget < 2600) begin
         tick();
         budget++;
      end
      check_eq({name, " finished_in_budget"}, 32'(budget < 2600), 32'd1);
      repeat (3) tick();
      check_eq({name, " write_count"}, obs_pkt.size(), exp_pkt.size());
      cnt = (obs_pkt.size() < exp_pkt.size()) ? obs_pkt.size() : exp_pkt.size();
      for (int k = 0; k < cnt; k++) begin
         check_eq($sformatf("%s pkt%0d", name, k), 32'(obs_pkt[k]), 32'(exp_pkt[k]));
         check_eq($sformatf("%s wr_time%0d", name, k), obs_w_edge[k] - n, exp_w_off[k]);
      end
      check_eq({name, " done_pulses"}, obs_done, exp_done);
      check_eq({name, " fail_pulses"}, obs_fail, exp_fail);
      check_eq({name, " end_time"}, end_edge - n, exp_end_off);
      check_eq({name, " rx_reads"}, obs_reads, exp_reads);
      check_eq({name, " illegal"}, 32'(illegal_o), 32'(exp_illegal));
      check_eq({name, " busy_at_end"}, 32'(busy_o), 32'd0);
      check_eq({name, " stream_mode_eq_busy"}, dsm_bad, 0);
      check_eq({name, " write_while_full"}, wrote_full, 0);
   endtask

   task automatic set_plan(input int a_kind, input int d);
      for (int a = 0; a < MAX_ATT; a++) begin
         act[a]      = a_kind;
         dly[a]      = d;
         bad_byte[a] = 8'h55;
      end
   endtask

   task automatic check_quiet(input string name);
      check_eq({name, " write"},   32'(tx_fifo_write_o),    32'd0);
      check_eq({name, " read"},    32'(rx_fifo_read_o),     32'd0);
      check_eq({name, " data_tx"}, 32'(data_tx_o),          32'd0);
      check_eq({name, " busy"},    32'(busy_o),             32'd0);
      check_eq({name, " stream"},  32'(data_stream_mode_o), 32'd0);
      check_eq({name, " done"},    32'(done_o),             32'd0);
      check_eq({name, " fail"},    32'(fail_o),             32'd0);
      check_eq({name, " illegal"}, 32'(illegal_o),          32'd0);
   endtask

   initial begin
      int guard;
      rst_n_i = 1'b0; start_i = 1'b0; tx_fifo_full_i = 1'b0;
      rx_fifo_empty_i = 1'b1; data_rx_i = 8'hFF; config_i = '0;
      set_plan(ACT_ACK, 10);
      clear_obs();
      repeat (3) tick();
      check_quiet("reset");
      rst_n_i = 1'b1;
      repeat (2) tick();

      c_dw = 2'b11; c_par = 2'b01; c_sb = 2'b00; full_rel = 0;
      set_plan(ACT_ACK, 10);
      run_scenario("happy");

      set_plan(ACT_ACK, 10);
      act[2] = ACT_DROP; act[3] = ACT_DROP;
      run_scenario("timeout_recover");

      set_plan(ACT_DROP, 10);
      run_scenario("exhaust");

      set_plan(ACT_ACK, 10);
      act[1] = ACT_BAD;
      run_scenario("bad_reply");

      c_sb = 2'b11; full_rel = 20;
      set_plan(ACT_ACK, 7);
      run_scenario("backpressure");

      c_dw = 2'b01; c_par = 2'b10; c_sb = 2'b10; full_rel = 0;
      set_plan(ACT_ACK, 10);
      dly[1] = T;
      run_scenario("rx_at_expiry");

      // Reset while waiting for the step-3 acknowledge.
      c_sb = 2'b11;
      set_plan(ACT_ACK, 30);
      clear_obs();
      config_i   = {c_dw, c_par, c_sb};
      full_until = 0;
      start_i    = 1'b1;
      guard      = 0;
      while (obs_pkt.size() < 4 && guard < 1000) begin
         tick();
         guard++;
      end
      check_eq("midreset reached_step3", obs_pkt.size(), 4);
      repeat (5) tick();
      sched_valid = 0;
      rst_n_i = 1'b0;
      tick();
      check_quiet("midreset");
      rst_n_i = 1'b1;
      clear_obs();
      repeat (150) tick();
      check_eq("midreset no_fail", obs_fail, 0);
      check_eq("midreset no_write", obs_pkt.size(), 0);

      for (int i = 0; i < 10; i++) begin
         c_dw     = 2'($urandom_range(0, 3));
         c_par    = 2'($urandom_range(0, 3));
         c_sb     = 2'($urandom_range(0, 3));
         full_rel = $urandom_range(0, 5);
         for (int a = 0; a < MAX_ATT; a++) begin
            int p = $urandom_range(0, 99);
            act[a]      = (p < 75) ? ACT_ACK : ((p < 95) ? ACT_DROP : ACT_BAD);
            dly[a]      = $urandom_range(1, T);
            bad_byte[a] = 8'($urandom_range(0, 254));
         end
         run_scenario($sformatf("rnd%0d", i));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
